baccarat_round_ctrl: RTL and testbench

- Self-contained controller for one full baccarat round, plus multi-round win/loss/tie tallies.
- Generalises the lab2 dealer datapath and state machine:
  - takes cards from an external shoe over a valid/ready handshake instead of an internal free-running card counter;
  - applies the complete third-card rules;
  - reports a tie;
  - keeps saturating per-outcome tallies across rounds.
- Sits between the card source (dealcard/shoe) and the HEX/LEDR display logic in the top level.

---
 rtl/baccarat_round_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_baccarat_round_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_round_ctrl.sv
// Baccarat round controller: deals one full round from an external card
// shoe, applies the third-card rules, registers the outcome and keeps
// saturating per-outcome tallies plus a wrapping round counter.
//
// Card handshake: card_ready is high exactly in the six deal states
// (P1, D1, P2, D2, P3, D3) and depends only on the current state. A card
// transfers on any rising edge where card_valid and card_ready are both 1.
// A transferred code of 1..13 is latched into the current slot and the
// state advances. A transferred code of 0/14/15 is consumed without being
// latched, sets the sticky proto_err and leaves the state unchanged.
//
// Result timing: the outcome flags, done and the tallies are registered on
// the edge that ends the RESULT cycle, so they become visible together in
// the first HOLD cycle, where done is high for exactly that one cycle.
module baccarat_round_ctrl #(
  parameter int TALLY_W = 8,
  parameter int ROUND_W = 10
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               start,
  input  logic               clear_tally,
  input  logic [3:0]         card_in,
  input  logic               card_valid,
  output logic               card_ready,
  output logic [3:0]         pcard1,
  output logic [3:0]         pcard2,
  output logic [3:0]         pcard3,
  output logic [3:0]         dcard1,
  output logic [3:0]         dcard2,
  output logic [3:0]         dcard3,
  output logic [3:0]         pscore,
  output logic [3:0]         dscore,
  output logic               player_win,
  output logic               dealer_win,
  output logic               tie,
  output logic               done,
  output logic               proto_err,
  output logic [TALLY_W-1:0] pwins,
  output logic [TALLY_W-1:0] dwins,
  output logic [TALLY_W-1:0] ties,
  output logic [ROUND_W-1:0] rounds,
  output logic [3:0]         state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_P1     = 4'd1,
    S_D1     = 4'd2,
    S_P2     = 4'd3,
    S_D2     = 4'd4,
    S_CHK    = 4'd5,
    S_P3     = 4'd6,
    S_BCHK   = 4'd7,
    S_D3     = 4'd8,
    S_RESULT = 4'd9,
    S_HOLD   = 4'd10
  } state_t;

  localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

  state_t     state;
  state_t     state_nx;
  logic       code_ok;
  logic       xfer;
  logic       take_card;
  logic       bad_card;
  logic       round_start;
  logic       natural;
  logic       banker_draw;
  logic [3:0] p3_val;

  // Baccarat value of a card code: 1..9 face value, tens and faces count 0.
  function automatic logic [3:0] card_val(input logic [3:0] code);
    card_val = (code >= 4'd1 && code <= 4'd9) ? code : 4'd0;
  endfunction

  // Hand value mod 10; the raw sum of three cards never exceeds 27.
  function automatic logic [3:0] hand_score(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] sum;
    sum = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
    if (sum >= 5'd20) begin
      sum = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      sum = sum - 5'd10;
    end
    hand_score = sum[3:0];
  endfunction

  // Scores are live views of the card registers; empty slots count 0.
  assign pscore = hand_score(pcard1, pcard2, pcard3);
  assign dscore = hand_score(dcard1, dcard2, dcard3);

  // Handshake qualifiers shared by the FSM and the datapath.
  assign card_ready  = (state == S_P1) || (state == S_D1) || (state == S_P2) ||
                       (state == S_D2) || (state == S_P3) || (state == S_D3);
  assign code_ok     = (card_in >= 4'd1) && (card_in <= 4'd13);
  assign xfer        = card_valid && card_ready;
  assign take_card   = xfer && code_ok;
  assign bad_card    = xfer && !code_ok;
  assign round_start = ((state == S_IDLE) || (state == S_HOLD)) && start;
  assign natural     = (pscore >= 4'd8) || (dscore >= 4'd8);
  assign state_dbg   = state;

  // Banker third-card decision, based on the player's third card if any.
  always_comb begin
    p3_val      = card_val(pcard3);
    banker_draw = 1'b0;
    if (pcard3 == 4'd0) begin
      banker_draw = (dscore <= 4'd5);
    end else begin
      case (dscore)
        4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
        4'd3:             banker_draw = (p3_val != 4'd8);
        4'd4:             banker_draw = (p3_val >= 4'd2) && (p3_val <= 4'd7);
        4'd5:             banker_draw = (p3_val >= 4'd4) && (p3_val <= 4'd7);
        4'd6:             banker_draw = (p3_val >= 4'd6) && (p3_val <= 4'd7);
        default:          banker_draw = 1'b0;
      endcase
    end
  end

  // Next-state logic for the deal sequence and decision points.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_HOLD: begin
        if (start) state_nx = S_P1;
      end
      S_P1: if (take_card) state_nx = S_D1;
      S_D1: if (take_card) state_nx = S_P2;
      S_P2: if (take_card) state_nx = S_D2;
      S_D2: if (take_card) state_nx = S_CHK;
      S_CHK: begin
        if (natural) begin
          state_nx = S_RESULT;
        end else if (pscore <= 4'd5) begin
          state_nx = S_P3;
        end else begin
          state_nx = S_BCHK;
        end
      end
      S_P3: if (take_card) state_nx = S_BCHK;
      S_BCHK: begin
        state_nx = banker_draw ? S_D3 : S_RESULT;
      end
      S_D3: if (take_card) state_nx = S_RESULT;
      S_RESULT: state_nx = S_HOLD;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Card slots: cleared when a round begins, filled one per accepted card.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      pcard1 <= 4'd0;
      pcard2 <= 4'd0;
      pcard3 <= 4'd0;
      dcard1 <= 4'd0;
      dcard2 <= 4'd0;
      dcard3 <= 4'd0;
    end else if (round_start) begin
      pcard1 <= 4'd0;
      pcard2 <= 4'd0;
      pcard3 <= 4'd0;
      dcard1 <= 4'd0;
      dcard2 <= 4'd0;
      dcard3 <= 4'd0;
    end else if (take_card) begin
      case (state)
        S_P1:    pcard1 <= card_in;
        S_D1:    dcard1 <= card_in;
        S_P2:    pcard2 <= card_in;
        S_D2:    dcard2 <= card_in;
        S_P3:    pcard3 <= card_in;
        S_D3:    dcard3 <= card_in;
        default: ;
      endcase
    end
  end

  // Outcome flags and the one-cycle done pulse, registered at end of RESULT.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      player_win <= 1'b0;
      dealer_win <= 1'b0;
      tie        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == S_RESULT);
      if (round_start) begin
        player_win <= 1'b0;
        dealer_win <= 1'b0;
        tie        <= 1'b0;
      end else if (state == S_RESULT) begin
        player_win <= (pscore > dscore);
        dealer_win <= (dscore > pscore);
        tie        <= (pscore == dscore);
      end
    end
  end

  // Sticky protocol error: any consumed code outside 1..13.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      proto_err <= 1'b0;
    end else if (bad_card) begin
      proto_err <= 1'b1;
    end
  end

  // Tallies saturate, round count wraps; a clear beats a same-cycle update.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      pwins  <= '0;
      dwins  <= '0;
      ties   <= '0;
      rounds <= '0;
    end else if (clear_tally) begin
      pwins  <= '0;
      dwins  <= '0;
      ties   <= '0;
      rounds <= '0;
    end else if (state == S_RESULT) begin
      if (pscore > dscore) begin
        if (pwins != TALLY_MAX) pwins <= pwins + 1'b1;
      end else if (dscore > pscore) begin
        if (dwins != TALLY_MAX) dwins <= dwins + 1'b1;
      end else begin
        if (ties != TALLY_MAX) ties <= ties + 1'b1;
      end
      rounds <= rounds + 1'b1;
    end
  end

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Bench for baccarat_round_ctrl: a game-level model of each round, a
// per-cycle compare process, directed rounds with literal expectations and
// randomized rounds with gaps and invalid card codes.
module tb_baccarat_round_ctrl;
  localparam int TW   = 2;
  localparam int RW   = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic          slow_clock = 1'b0;
  logic          resetb;
  logic          start;
  logic          clear_tally;
  logic [3:0]    card_in;
  logic          card_valid;
  logic          card_ready;
  logic [3:0]    pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0]    pscore, dscore;
  logic          player_win, dealer_win, tie, done, proto_err;
  logic [TW-1:0] pwins, dwins, ties;
  logic [RW-1:0] rounds;
  logic [3:0]    state_dbg;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int played = 0;
  bit mon_en = 1'b0;

  // model state
  logic [3:0] exp_c[6];  // p1 p2 p3 d1 d2 d3
  bit exp_proto, exp_pw, exp_dw, exp_tie;
  int m_pw, m_dw, m_ti, m_rounds;
  int rnd_out;           // 1 player, 2 banker, 3 tie

  baccarat_round_ctrl #(.TALLY_W(TW), .ROUND_W(RW)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .start(start),
    .clear_tally(clear_tally), .card_in(card_in), .card_valid(card_valid),
    .card_ready(card_ready),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore),
    .player_win(player_win), .dealer_win(dealer_win), .tie(tie),
    .done(done), .proto_err(proto_err),
    .pwins(pwins), .dwins(dwins), .ties(ties), .rounds(rounds),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 slow_clock = ~slow_clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT event did not occur within bound at %0t", name, $time);
  endtask

  function automatic int cval(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int score3(input int a, input int b, input int c);
    return (cval(a) + cval(b) + cval(c)) % 10;
  endfunction

  // Punto banco tableau for the banker.
  function automatic bit banker_draws(input int bt, input bit pdrew, input int v);
    if (bt >= 7) return 1'b0;
    if (!pdrew) return bt <= 5;
    case (bt)
      0, 1, 2: return 1'b1;
      3:       return v != 8;
      4:       return v >= 2 && v <= 7;
      5:       return v >= 4 && v <= 7;
      6:       return v >= 6 && v <= 7;
      default: return 1'b0;
    endcase
  endfunction

  // Per-cycle compare process, sampled 1 time unit after the rising edge.
  always @(posedge slow_clock) begin
    #1;
    if (mon_en) begin
      if (done) begin
        done_cnt++;
        exp_pw  = (rnd_out == 1);
        exp_dw  = (rnd_out == 2);
        exp_tie = (rnd_out == 3);
      end
      if (clear_tally) begin
        m_pw = 0; m_dw = 0; m_ti = 0; m_rounds = 0;
      end else if (done) begin
        if (rnd_out == 1 && m_pw < TMAX) m_pw++;
        if (rnd_out == 2 && m_dw < TMAX) m_dw++;
        if (rnd_out == 3 && m_ti < TMAX) m_ti++;
        m_rounds = (m_rounds + 1) % (1 << RW);
      end
      check("pcard1", pcard1, exp_c[0]);
      check("pcard2", pcard2, exp_c[1]);
      check("pcard3", pcard3, exp_c[2]);
      check("dcard1", dcard1, exp_c[3]);
      check("dcard2", dcard2, exp_c[4]);
      check("dcard3", dcard3, exp_c[5]);
      check("pscore", pscore, score3(exp_c[0], exp_c[1], exp_c[2]));
      check("dscore", dscore, score3(exp_c[3], exp_c[4], exp_c[5]));
      check("player_win", player_win, exp_pw);
      check("dealer_win", dealer_win, exp_dw);
      check("tie", tie, exp_tie);
      check("proto_err", proto_err, exp_proto);
      check("pwins", pwins, m_pw);
      check("dwins", dwins, m_dw);
      check("ties", ties, m_ti);
      check("rounds", rounds, m_rounds);
    end
  end

  // Present one card (slot<0 means an invalid code) and wait for its transfer.
  task automatic offer(input logic [3:0] c, input int slot);
    int w;
    w = 0;
    card_in = c;
    card_valid = 1'b1;
    while (!card_ready && w < 20) begin
      @(negedge slow_clock);
      w++;
    end
    if (!card_ready) begin
      fail_now("card_ready_wait");
      card_valid = 1'b0;
      return;
    end
    if (slot >= 0) exp_c[slot] = c;
    else exp_proto = 1'b1;
    @(negedge slow_clock);
    card_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    for (int i = 0; i < 6; i++) exp_c[i] = 4'd0;
    exp_pw = 1'b0; exp_dw = 1'b0; exp_tie = 1'b0;
    @(negedge slow_clock);
    start = 1'b0;
    check("cards_clear_on_start",
          pcard1 | pcard2 | pcard3 | dcard1 | dcard2 | dcard3, 0);
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!done && w < 12) begin
      @(negedge slow_clock);
      w++;
    end
    if (!done) begin
      fail_now("done_wait");
      return;
    end
    played++;
    @(negedge slow_clock);
    check("done_width", done, 0);
  endtask

  // Play one round from a deck in shoe order; the model decides the draws.
  task automatic play_round(input logic [3:0] deck[6], input bit gaps,
                            input bit errs, input bit hs_test, input bit clr_res);
    logic [3:0] pc[3];
    logic [3:0] dc[3];
    logic [3:0] seq_c[6];
    int seq_s[6];
    int n, ps, ds;
    bit pdrew;
    pc = '{4'd0, 4'd0, 4'd0};
    dc = '{4'd0, 4'd0, 4'd0};
    pc[0] = deck[0]; dc[0] = deck[1]; pc[1] = deck[2]; dc[1] = deck[3];
    seq_c[0] = deck[0]; seq_s[0] = 0;
    seq_c[1] = deck[1]; seq_s[1] = 3;
    seq_c[2] = deck[2]; seq_s[2] = 1;
    seq_c[3] = deck[3]; seq_s[3] = 4;
    n = 4;
    ps = score3(pc[0], pc[1], 0);
    ds = score3(dc[0], dc[1], 0);
    pdrew = 1'b0;
    if (ps < 8 && ds < 8) begin
      if (ps <= 5) begin
        pdrew = 1'b1;
        pc[2] = deck[n]; seq_c[n] = deck[n]; seq_s[n] = 2; n++;
      end
      if (banker_draws(ds, pdrew, cval(pc[2]))) begin
        dc[2] = deck[n]; seq_c[n] = deck[n]; seq_s[n] = 5; n++;
      end
    end
    ps = score3(pc[0], pc[1], pc[2]);
    ds = score3(dc[0], dc[1], dc[2]);
    rnd_out = (ps > ds) ? 1 : (ds > ps) ? 2 : 3;

    do_start();
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        card_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge slow_clock);
      end
      if (errs && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       offer(4'd0, -1);
          1:       offer(4'd14, -1);
          default: offer(4'd15, -1);
        endcase
      end
      if (hs_test && i == 1) begin
        for (int k = 0; k < 5; k++) begin
          check("ready_while_idle_valid", card_ready, 1);
          check("pcard1_hold", pcard1, deck[0]);
          start = (k == 2);
          @(negedge slow_clock);
        end
        start = 1'b0;
        offer(4'd14, -1);
        check("proto_err_after_14", proto_err, 1);
        check("dcard1_not_written", dcard1, 0);
      end
      offer(seq_c[i], seq_s[i]);
    end
    if (clr_res) begin
      @(negedge slow_clock);
      check("done_low_in_result", done, 0);
      clear_tally = 1'b1;
      @(negedge slow_clock);
      clear_tally = 1'b0;
      check("done_after_result", done, 1);
      check("pwins_clr_in_result", pwins, 0);
      check("rounds_clr_in_result", rounds, 0);
    end
    wait_done();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) exp_c[i] = 4'd0;
    exp_proto = 1'b0; exp_pw = 1'b0; exp_dw = 1'b0; exp_tie = 1'b0;
    m_pw = 0; m_dw = 0; m_ti = 0; m_rounds = 0;
  endtask

  initial begin
    logic [3:0] dk[6];
    resetb = 1'b0; start = 1'b0; clear_tally = 1'b0;
    card_in = 4'd0; card_valid = 1'b0;
    model_reset();
    rnd_out = 0;
    repeat (2) @(negedge slow_clock);
    check("rst_card_ready", card_ready, 0);
    check("rst_cards", pcard1 | pcard2 | pcard3 | dcard1 | dcard2 | dcard3, 0);
    check("rst_done", done, 0);
    check("rst_rounds", rounds, 0);
    resetb = 1'b1;
    mon_en = 1'b1;
    @(negedge slow_clock);

    // natural, valid held high throughout
    dk = '{4'd3, 4'd3, 4'd5, 4'd7, 4'd0, 4'd0};
    play_round(dk, 1'b0, 1'b0, 1'b0, 1'b0);
    check("nat_pscore", pscore, 8);
    check("nat_dscore", dscore, 0);
    check("nat_pcard3", pcard3, 0);
    check("nat_dcard3", dcard3, 0);
    check("nat_player_win", player_win, 1);
    check("nat_pwins", pwins, 1);
    check("nat_rounds", rounds, 1);

    // both draw
    dk = '{4'd2, 4'd13, 4'd2, 4'd6, 4'd7, 4'd9};
    play_round(dk, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bd_pscore", pscore, 1);
    check("bd_dscore", dscore, 5);
    check("bd_dealer_win", dealer_win, 1);
    check("bd_dwins", dwins, 1);

    // player stands, banker draws
    dk = '{4'd6, 4'd2, 4'd13, 4'd1, 4'd4, 4'd0};
    play_round(dk, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ps_pcard3", pcard3, 0);
    check("ps_dscore", dscore, 7);
    check("ps_dealer_win", dealer_win, 1);

    // tie, both stand
    dk = '{4'd4, 4'd5, 4'd3, 4'd2, 4'd0, 4'd0};
    play_round(dk, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tie_flag", tie, 1);
    check("tie_ties", ties, 1);
    check("tie_dcard3", dcard3, 0);

    // handshake stall, ignored start, invalid code
    dk = '{4'd9, 4'd1, 4'd1, 4'd1, 4'd8, 4'd5};
    play_round(dk, 1'b0, 1'b0, 1'b1, 1'b0);
    check("hs_pscore", pscore, 8);
    check("hs_dscore", dscore, 7);

    // asynchronous reset mid-round, in P2
    do_start();
    offer(4'd5, 0);
    offer(4'd6, 3);
    mon_en = 1'b0;
    #2 resetb = 1'b0;
    #1;
    check("arst_cards", pcard1 | pcard2 | pcard3 | dcard1 | dcard2 | dcard3, 0);
    check("arst_scores", pscore | dscore, 0);
    check("arst_flags", {player_win, dealer_win, tie, done, proto_err}, 0);
    check("arst_tallies", pwins | dwins | ties, 0);
    check("arst_rounds", rounds, 0);
    check("arst_card_ready", card_ready, 0);
    model_reset();
    @(negedge slow_clock);
    resetb = 1'b1;
    mon_en = 1'b1;
    @(negedge slow_clock);

    // saturation
    clear_tally = 1'b1;
    @(negedge slow_clock);
    clear_tally = 1'b0;
    dk = '{4'd3, 4'd3, 4'd5, 4'd7, 4'd0, 4'd0};
    repeat (5) play_round(dk, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_pwins", pwins, 3);
    check("sat_rounds", rounds, 5);

    // clear in the RESULT cycle
    play_round(dk, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_pwins", pwins, 0);
    check("clr_player_win", player_win, 1);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 6; i++) dk[i] = 4'($urandom_range(1, 13));
      play_round(dk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge slow_clock);
    end

    check("done_pulse_count", done_cnt, played);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
